// File: rtl/fpa_arb_if.sv
// Bundle of request, adder and response signals between compute clients, the
// shared FP adder and the fpa_arb sequencer.
interface fpa_arb_if;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_a_0, req_a_1;
    logic [31:0] req_b_0, req_b_1;
    logic        req_sub_0, req_sub_1;
    logic        fpa_in_vld;
    logic [31:0] fpa_a, fpa_b, fpa_c;
    logic        rsp_valid_0, rsp_valid_1;
    logic        rsp_ready_0, rsp_ready_1;
    logic [31:0] rsp_data_0, rsp_data_1;
    logic        idle;

    modport slave (
        input  req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
               req_sub_0, req_sub_1, fpa_c, rsp_ready_0, rsp_ready_1,
        output req_ready_0, req_ready_1, fpa_in_vld, fpa_a, fpa_b,
               rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1, idle
    );

    modport master (
        output req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
               req_sub_0, req_sub_1, fpa_c, rsp_ready_0, rsp_ready_1,
        input  req_ready_0, req_ready_1, fpa_in_vld, fpa_a, fpa_b,
               rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1, idle
    );
endinterface

// File: rtl/fpa_arb.sv
// Round-robin arbiter feeding a shared fixed-latency FP adder; per-requester
// credits bound in-flight plus stored results so the response FIFOs never overflow.
module fpa_arb #(
    parameter int LAT       = 3,
    parameter int RSP_DEPTH = 4
) (
    input logic      clk,
    input logic      rst_n,
    fpa_arb_if.slave bus
);
    localparam int DATA_W = 32;
    localparam int PW     = $clog2(RSP_DEPTH);
    localparam int CW     = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(RSP_DEPTH);

    logic [CW-1:0]     credit     [2];
    logic [CW-1:0]     credit_nxt [2];
    logic [CW-1:0]     cnt        [2];
    logic [PW-1:0]     wptr       [2];
    logic [PW-1:0]     rptr       [2];
    logic [DATA_W-1:0] mem        [2][RSP_DEPTH];
    logic [1:0]        elig, gnt, pop, wr, rsp_rdy;
    logic              last;
    logic              idle_r;
    logic [DATA_W-1:0] win_a, win_b;
    logic [DATA_W-1:0] a_p0, b_p0;
    logic              tag_vld [LAT+1];
    logic              tag_id  [LAT+1];

    assign rsp_rdy = {bus.rsp_ready_1, bus.rsp_ready_0};
    assign elig[0] = bus.req_valid_0 && (credit[0] < FULL);
    assign elig[1] = bus.req_valid_1 && (credit[1] < FULL);

    // Grant only out of reset; on a tie the requester that did not win last goes.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (&elig) gnt = last ? 2'b01 : 2'b10;
            else       gnt = elig;
        end
    end

    assign win_a = gnt[1] ? bus.req_a_1 : bus.req_a_0;
    assign win_b = gnt[1] ? {bus.req_b_1[DATA_W-1] ^ bus.req_sub_1, bus.req_b_1[DATA_W-2:0]}
                          : {bus.req_b_0[DATA_W-1] ^ bus.req_sub_0, bus.req_b_0[DATA_W-2:0]};

    always_comb begin
        for (int x = 0; x < 2; x++) begin
            pop[x]        = (cnt[x] != '0) && rsp_rdy[x];
            wr[x]         = tag_vld[LAT] && (tag_id[LAT] == x[0]);
            credit_nxt[x] = credit[x] + CW'(gnt[x]) - CW'(pop[x]);
        end
    end

    // Stage p0 is the issue register; tag entry 0 travels with it, entry LAT
    // marks the cycle in which fpa_c belongs to that op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last   <= 1'b1;
            a_p0   <= '0;
            b_p0   <= '0;
            idle_r <= 1'b1;
            for (int k = 0; k <= LAT; k++) begin
                tag_vld[k] <= 1'b0;
                tag_id[k]  <= 1'b0;
            end
            for (int x = 0; x < 2; x++) begin
                credit[x] <= '0;
                cnt[x]    <= '0;
                wptr[x]   <= '0;
                rptr[x]   <= '0;
            end
        end else begin
            tag_vld[0] <= |gnt;
            tag_id[0]  <= gnt[1];
            if (|gnt) begin
                last <= gnt[1];
                a_p0 <= win_a;
                b_p0 <= win_b;
            end
            for (int k = 1; k <= LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
            for (int x = 0; x < 2; x++) begin
                credit[x] <= credit_nxt[x];
                cnt[x]    <= cnt[x] + CW'(wr[x]) - CW'(pop[x]);
                wptr[x]   <= wptr[x] + PW'(wr[x]);
                rptr[x]   <= rptr[x] + PW'(pop[x]);
            end
            idle_r <= (credit_nxt[0] == '0) && (credit_nxt[1] == '0);
        end
    end

    always_ff @(posedge clk) begin
        for (int x = 0; x < 2; x++)
            if (wr[x]) mem[x][wptr[x]] <= bus.fpa_c;
    end

    assign bus.req_ready_0 = gnt[0];
    assign bus.req_ready_1 = gnt[1];
    assign bus.fpa_in_vld  = tag_vld[0];
    assign bus.fpa_a       = a_p0;
    assign bus.fpa_b       = b_p0;
    assign bus.rsp_valid_0 = (cnt[0] != '0);
    assign bus.rsp_valid_1 = (cnt[1] != '0);
    assign bus.rsp_data_0  = (cnt[0] != '0) ? mem[0][rptr[0]] : '0;
    assign bus.rsp_data_1  = (cnt[1] != '0) ? mem[1][rptr[1]] : '0;
    assign bus.idle        = idle_r;
endmodule
